// File: rtl/oled_spi_monitor.sv
// oled_spi_monitor: passive sniffer for an OLED SPI link.
// Recovers bytes, decodes window commands and tracks the pixel pointer.
module oled_spi_monitor #(
    parameter int NUM_COL     = 96,
    parameter int NUM_ROW     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_CS,
    input  logic       i_SCK,
    input  logic       i_MOSI,
    input  logic       i_DC,
    input  logic       i_RES,
    output logic [7:0] o_BYTE,
    output logic       o_BYTE_DC,
    output logic       o_BYTE_VALID,
    output logic       o_CMD_VALID,
    output logic       o_PIX_VALID,
    output logic [6:0] o_PIX_X,
    output logic [5:0] o_PIX_Y,
    output logic [7:0] o_PIX_DATA,
    output logic       o_DISPLAY_ON,
    output logic       o_FRAME_ERR
);

    localparam logic [6:0] COL_LAST = 7'(NUM_COL - 1);
    localparam logic [5:0] ROW_LAST = 6'(NUM_ROW - 1);

    typedef enum logic [2:0] {
        IDLE,
        COL_S,
        COL_E,
        ROW_S,
        ROW_E
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q, res_sync_q;
    logic cs_s, sck_s, mosi_s, dc_s, res_s;
    logic cs_prev_q, sck_prev_q;
    logic sck_rise, cs_rise, cs_fall;

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       full_q, full_d;
    logic       ferr_q, ferr_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;
    logic       bv_q, bv_d;

    state_t     state_q, state_d;
    logic [6:0] col_s_q, col_s_d, col_e_q, col_e_d;
    logic [5:0] row_s_q, row_s_d, row_e_q, row_e_d;
    logic [6:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic       on_q, on_d;
    logic       cmd_v_q, cmd_v_d;
    logic       pix_v_q, pix_v_d;
    logic [6:0] pix_x_q, pix_x_d;
    logic [5:0] pix_y_q, pix_y_d;
    logic [7:0] pix_d_q, pix_d_d;

    // Input synchronizers; CS and SCK idle high so no false edge after reset
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '1;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            res_sync_q  <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_CS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], i_DC};
            res_sync_q  <= {res_sync_q[SYNC_STAGES-2:0], i_RES};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s     = dc_sync_q[SYNC_STAGES-1];
    assign res_s    = res_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    // Byte receiver: shift on SCK rise, publish the byte one cycle after bit 8
    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        full_d    = 1'b0;
        ferr_d    = 1'b0;
        byte_d    = byte_q;
        byte_dc_d = byte_dc_q;
        bv_d      = 1'b0;
        if (full_q) begin
            byte_d    = sr_q;
            byte_dc_d = dc_s;
            bv_d      = 1'b1;
        end
        if (cs_rise) begin
            cnt_d  = 3'd0;
            ferr_d = (cnt_q != 3'd0);
        end else if (cs_fall) begin
            cnt_d = 3'd0;
        end else if (sck_rise) begin
            sr_d   = {sr_q[6:0], mosi_s};
            cnt_d  = cnt_q + 3'd1;
            full_d = (cnt_q == 3'd7);
        end
        if (!res_s) begin
            cnt_d  = 3'd0;
            full_d = 1'b0;
            ferr_d = 1'b0;
            bv_d   = 1'b0;
        end
    end

    // Parser: window commands, display on/off and pixel pointer advance
    always_comb begin
        state_d = state_q;
        col_s_d = col_s_q;
        col_e_d = col_e_q;
        row_s_d = row_s_q;
        row_e_d = row_e_q;
        x_d     = x_q;
        y_d     = y_q;
        on_d    = on_q;
        cmd_v_d = 1'b0;
        pix_v_d = 1'b0;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        pix_d_d = pix_d_q;
        if (bv_q) begin
            if (byte_dc_q) begin
                pix_v_d = 1'b1;
                pix_x_d = x_q;
                pix_y_d = y_q;
                pix_d_d = byte_q;
                if (x_q == col_e_q) begin
                    x_d = col_s_q;
                    y_d = (y_q == row_e_q) ? row_s_q : y_q + 6'd1;
                end else begin
                    x_d = x_q + 7'd1;
                end
            end else begin
                cmd_v_d = 1'b1;
                unique case (state_q)
                    IDLE: begin
                        if (byte_q == 8'h15) begin
                            state_d = COL_S;
                        end else if (byte_q == 8'h75) begin
                            state_d = ROW_S;
                        end else if (byte_q == 8'hAF) begin
                            on_d = 1'b1;
                        end else if (byte_q == 8'hAE) begin
                            on_d = 1'b0;
                        end
                    end
                    COL_S: begin
                        col_s_d = byte_q[6:0];
                        state_d = COL_E;
                    end
                    COL_E: begin
                        col_e_d = byte_q[6:0];
                        x_d     = col_s_q;
                        state_d = IDLE;
                    end
                    ROW_S: begin
                        row_s_d = byte_q[5:0];
                        state_d = ROW_E;
                    end
                    ROW_E: begin
                        row_e_d = byte_q[5:0];
                        y_d     = row_s_q;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        if (!res_s) begin
            state_d = IDLE;
            col_s_d = 7'd0;
            col_e_d = COL_LAST;
            row_s_d = 6'd0;
            row_e_d = ROW_LAST;
            x_d     = 7'd0;
            y_d     = 6'd0;
            on_d    = 1'b0;
            cmd_v_d = 1'b0;
            pix_v_d = 1'b0;
        end
    end

    // State register for receiver and parser
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q     <= 3'd0;
            sr_q      <= 8'd0;
            full_q    <= 1'b0;
            ferr_q    <= 1'b0;
            byte_q    <= 8'd0;
            byte_dc_q <= 1'b0;
            bv_q      <= 1'b0;
            state_q   <= IDLE;
            col_s_q   <= 7'd0;
            col_e_q   <= COL_LAST;
            row_s_q   <= 6'd0;
            row_e_q   <= ROW_LAST;
            x_q       <= 7'd0;
            y_q       <= 6'd0;
            on_q      <= 1'b0;
            cmd_v_q   <= 1'b0;
            pix_v_q   <= 1'b0;
            pix_x_q   <= 7'd0;
            pix_y_q   <= 6'd0;
            pix_d_q   <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            full_q    <= full_d;
            ferr_q    <= ferr_d;
            byte_q    <= byte_d;
            byte_dc_q <= byte_dc_d;
            bv_q      <= bv_d;
            state_q   <= state_d;
            col_s_q   <= col_s_d;
            col_e_q   <= col_e_d;
            row_s_q   <= row_s_d;
            row_e_q   <= row_e_d;
            x_q       <= x_d;
            y_q       <= y_d;
            on_q      <= on_d;
            cmd_v_q   <= cmd_v_d;
            pix_v_q   <= pix_v_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            pix_d_q   <= pix_d_d;
        end
    end

    assign o_BYTE       = byte_q;
    assign o_BYTE_DC    = byte_dc_q;
    assign o_BYTE_VALID = bv_q;
    assign o_CMD_VALID  = cmd_v_q;
    assign o_PIX_VALID  = pix_v_q;
    assign o_PIX_X      = pix_x_q;
    assign o_PIX_Y      = pix_y_q;
    assign o_PIX_DATA   = pix_d_q;
    assign o_DISPLAY_ON = on_q;
    assign o_FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_oled_spi_monitor.sv
// tb_oled_spi_monitor: randomized bench for oled_spi_monitor.
// A high-level window/pointer model predicts bytes, commands and pixels.
module tb_oled_spi_monitor;

    localparam int NC = 96;
    localparam int NR = 64;
    localparam int SS = 2;

    logic       i_CLK = 1'b0;
    logic       i_RST, i_CS, i_SCK, i_MOSI, i_DC, i_RES;
    logic [7:0] o_BYTE, o_PIX_DATA;
    logic       o_BYTE_DC, o_BYTE_VALID, o_CMD_VALID, o_PIX_VALID;
    logic [6:0] o_PIX_X;
    logic [5:0] o_PIX_Y;
    logic       o_DISPLAY_ON, o_FRAME_ERR;

    always #5 i_CLK = ~i_CLK;

    oled_spi_monitor #(
        .NUM_COL(NC),
        .NUM_ROW(NR),
        .SYNC_STAGES(SS)
    ) dut (
        .i_CLK(i_CLK),
        .i_RST(i_RST),
        .i_CS(i_CS),
        .i_SCK(i_SCK),
        .i_MOSI(i_MOSI),
        .i_DC(i_DC),
        .i_RES(i_RES),
        .o_BYTE(o_BYTE),
        .o_BYTE_DC(o_BYTE_DC),
        .o_BYTE_VALID(o_BYTE_VALID),
        .o_CMD_VALID(o_CMD_VALID),
        .o_PIX_VALID(o_PIX_VALID),
        .o_PIX_X(o_PIX_X),
        .o_PIX_Y(o_PIX_Y),
        .o_PIX_DATA(o_PIX_DATA),
        .o_DISPLAY_ON(o_DISPLAY_ON),
        .o_FRAME_ERR(o_FRAME_ERR)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  obs_byte[$], exp_byte[$];
    logic [7:0]  obs_cmd[$], exp_cmd[$];
    logic [20:0] obs_pix[$], exp_pix[$];
    int   ferr_cnt = 0;
    int   cmd_bad = 0;
    int   pix_bad = 0;
    logic prev_bv = 1'b0;
    logic prev_dc = 1'b0;

    // Observation side: record every strobe and its relation to the byte strobe
    always @(negedge i_CLK) begin
        if (o_BYTE_VALID) obs_byte.push_back({o_BYTE_DC, o_BYTE});
        if (o_CMD_VALID) begin
            obs_cmd.push_back(o_BYTE);
            if (!(prev_bv && !prev_dc)) cmd_bad++;
        end
        if (o_PIX_VALID) begin
            obs_pix.push_back({o_PIX_X, o_PIX_Y, o_PIX_DATA});
            if (!(prev_bv && prev_dc)) pix_bad++;
        end
        if (o_FRAME_ERR) ferr_cnt++;
        prev_bv = o_BYTE_VALID;
        prev_dc = o_BYTE_DC;
    end

    // Reference model of the panel's address logic
    int m_cs, m_ce, m_rs, m_re, m_x, m_y, m_args;
    bit m_on, m_col;

    task automatic model_reset();
        m_cs = 0; m_ce = NC - 1;
        m_rs = 0; m_re = NR - 1;
        m_x = 0; m_y = 0; m_on = 0; m_args = 0; m_col = 0;
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] b);
        exp_byte.push_back({dc, b});
        if (!dc) begin
            exp_cmd.push_back(b);
            if (m_args == 2) begin
                if (m_col) m_cs = b % 128; else m_rs = b % 64;
                m_args = 1;
            end else if (m_args == 1) begin
                if (m_col) begin m_ce = b % 128; m_x = m_cs; end
                else begin m_re = b % 64; m_y = m_rs; end
                m_args = 0;
            end else if (b == 8'h15) begin m_col = 1; m_args = 2; end
            else if (b == 8'h75) begin m_col = 0; m_args = 2; end
            else if (b == 8'hAF) m_on = 1;
            else if (b == 8'hAE) m_on = 0;
        end else begin
            exp_pix.push_back({7'(m_x), 6'(m_y), b});
            if (m_x == m_ce) begin
                m_x = m_cs;
                m_y = (m_y == m_re) ? m_rs : (m_y + 1) % 64;
            end else begin
                m_x = (m_x + 1) % 128;
            end
        end
    endtask

    task automatic clear_q();
        obs_byte.delete(); exp_byte.delete();
        obs_cmd.delete(); exp_cmd.delete();
        obs_pix.delete(); exp_pix.delete();
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic send_bits(input int n, input logic [7:0] v, input logic dc);
        i_DC = dc;
        for (int i = 0; i < n; i++) begin
            @(negedge i_CLK);
            i_SCK = 1'b0;
            i_MOSI = v[7-i];
            clks(4);
            i_SCK = 1'b1;
            clks(4);
        end
        @(negedge i_CLK);
        i_SCK = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(8, b, dc);
        model_byte(dc, b);
        clks(SS + 6);
    endtask

    task automatic test_reset();
        i_RST = 1; i_CS = 1; i_SCK = 0; i_MOSI = 0; i_DC = 0; i_RES = 1;
        clks(4);
        checks++;
        if ({o_BYTE_VALID, o_CMD_VALID, o_PIX_VALID, o_FRAME_ERR} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000",
                     {o_BYTE_VALID, o_CMD_VALID, o_PIX_VALID, o_FRAME_ERR});
        end
        checks++;
        if ({o_BYTE_DC, o_BYTE} !== 9'h0) begin
            errors++;
            $display("FAIL reset_byte got %h exp 000", {o_BYTE_DC, o_BYTE});
        end
        checks++;
        if ({o_PIX_X, o_PIX_Y, o_PIX_DATA} !== 21'h0) begin
            errors++;
            $display("FAIL reset_pix got x=%0d y=%0d d=%h exp 0", o_PIX_X, o_PIX_Y, o_PIX_DATA);
        end
        checks++;
        if (o_DISPLAY_ON !== 1'b0) begin
            errors++;
            $display("FAIL reset_display got %b exp 0", o_DISPLAY_ON);
        end
        i_RST = 0;
        clks(SS + 4);
        model_reset();
        clear_q();
    endtask

    task automatic test_mid_reset();
        int f0;
        f0 = ferr_cnt;
        i_CS = 0;
        clks(SS + 3);
        send_bits(3, 8'hE0, 1'b0);
        clks(2);
        i_RST = 1;
        clks(2);
        i_RST = 0;
        model_reset();
        clks(SS + 4);
        send_byte(1'b0, 8'h3C);
        i_CS = 1;
        clks(SS + 4);
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL midrst_ferr got %0d exp %0d", ferr_cnt, f0);
        end
        checks++;
        if (obs_byte.size() != 1 || obs_byte[0] !== 9'h03C) begin
            errors++;
            $display("FAIL midrst_byte got n=%0d first=%h exp n=1 03c", obs_byte.size(),
                     (obs_byte.size() > 0) ? obs_byte[0] : 9'h1FF);
        end
        clear_q();
    endtask

    task automatic test_display_on();
        int f0;
        f0 = ferr_cnt;
        i_CS = 0;
        clks(SS + 3);
        send_byte(1'b0, 8'hAF);
        checks++;
        if (obs_byte.size() != 1 || obs_byte[0] !== 9'h0AF) begin
            errors++;
            $display("FAIL dispon_byte got n=%0d exp n=1 0af", obs_byte.size());
        end
        checks++;
        if (obs_cmd.size() != 1 || cmd_bad != 0) begin
            errors++;
            $display("FAIL dispon_cmd got n=%0d bad=%0d exp n=1 bad=0", obs_cmd.size(), cmd_bad);
        end
        checks++;
        if (o_DISPLAY_ON !== 1'b1) begin
            errors++;
            $display("FAIL dispon_flag got %b exp 1", o_DISPLAY_ON);
        end
        i_CS = 1;
        clks(SS + 4);
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL cs_clean_ferr got %0d exp %0d", ferr_cnt, f0);
        end
        clear_q();
    endtask

    task automatic test_window();
        logic [20:0] lit[7];
        lit[0] = {7'd16, 6'd5, 8'h01}; lit[1] = {7'd17, 6'd5, 8'h02};
        lit[2] = {7'd18, 6'd5, 8'h03}; lit[3] = {7'd16, 6'd6, 8'h04};
        lit[4] = {7'd17, 6'd6, 8'h05}; lit[5] = {7'd18, 6'd6, 8'h06};
        lit[6] = {7'd16, 6'd5, 8'h07};
        i_CS = 0;
        clks(SS + 3);
        send_byte(0, 8'h15); send_byte(0, 8'h10); send_byte(0, 8'h12);
        send_byte(0, 8'h75); send_byte(0, 8'h05); send_byte(0, 8'h06);
        for (int i = 1; i <= 7; i++) send_byte(1, 8'(i));
        checks++;
        if (obs_pix.size() != 7 || obs_cmd.size() != 6) begin
            errors++;
            $display("FAIL window_count got pix=%0d cmd=%0d exp 7 6", obs_pix.size(), obs_cmd.size());
        end
        for (int i = 0; i < 7 && i < obs_pix.size(); i++) begin
            checks++;
            if (obs_pix[i] !== lit[i]) begin
                errors++;
                $display("FAIL window_pix%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h", i,
                         obs_pix[i][20:14], obs_pix[i][13:8], obs_pix[i][7:0],
                         lit[i][20:14], lit[i][13:8], lit[i][7:0]);
            end
        end
        clear_q();
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        i_CS = 0;
        clks(SS + 3);
        send_bits(5, 8'($urandom), 1'b0);
        clks(3);
        i_CS = 1;
        clks(SS + 4);
        checks++;
        if (ferr_cnt != f0 + 1 || obs_byte.size() != 0) begin
            errors++;
            $display("FAIL frame_err got ferr=%0d bytes=%0d exp ferr=%0d bytes=0",
                     ferr_cnt - f0, obs_byte.size(), 1);
        end
        i_CS = 0;
        clks(SS + 3);
        send_byte(1'b0, 8'hA5);
        i_CS = 1;
        clks(SS + 4);
        checks++;
        if (obs_byte.size() != 1 || obs_byte[0] !== 9'h0A5 || ferr_cnt != f0 + 1) begin
            errors++;
            $display("FAIL frame_recover got n=%0d first=%h ferr=%0d exp n=1 0a5 ferr=1",
                     obs_byte.size(), (obs_byte.size() > 0) ? obs_byte[0] : 9'h1FF, ferr_cnt - f0);
        end
        clear_q();
    endtask

    task automatic test_latency();
        int lat;
        logic [7:0] v;
        v = 8'hC3;
        i_CS = 0;
        clks(SS + 3);
        send_bits(7, v, 1'b0);
        @(negedge i_CLK);
        i_MOSI = v[0];
        clks(4);
        i_SCK = 1'b1;
        lat = 0;
        do begin
            @(posedge i_CLK);
            #1;
            lat++;
        end while (!o_BYTE_VALID && lat < 20);
        checks++;
        if (lat != SS + 2 || o_BYTE !== v) begin
            errors++;
            $display("FAIL latency got %0d byte=%h exp %0d byte=%h", lat, o_BYTE, SS + 2, v);
        end
        clks(4);
        i_SCK = 1'b0;
        model_byte(1'b0, v);
        clks(SS + 6);
        clear_q();
    endtask

    task automatic test_full_panel();
        i_RST = 1;
        clks(2);
        i_RST = 0;
        model_reset();
        clks(SS + 4);
        clear_q();
        i_CS = 0;
        clks(SS + 3);
        for (int i = 0; i < 97; i++) send_byte(1, 8'($urandom));
        send_byte(0, 8'h15); send_byte(0, 8'h00); send_byte(0, 8'h00);
        for (int i = 0; i < 64; i++) send_byte(1, 8'($urandom));
        checks++;
        if (obs_pix.size() != exp_pix.size()) begin
            errors++;
            $display("FAIL panel_count got %0d exp %0d", obs_pix.size(), exp_pix.size());
        end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++;
            if (obs_pix[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL panel_pix%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h", i,
                         obs_pix[i][20:14], obs_pix[i][13:8], obs_pix[i][7:0],
                         exp_pix[i][20:14], exp_pix[i][13:8], exp_pix[i][7:0]);
            end
        end
        if (obs_pix.size() == 161) begin
            checks++;
            if (obs_pix[95][20:8] !== {7'd95, 6'd0} || obs_pix[96][20:8] !== {7'd0, 6'd1}) begin
                errors++;
                $display("FAIL panel_colwrap got %0d,%0d then %0d,%0d exp 95,0 then 0,1",
                         obs_pix[95][20:14], obs_pix[95][13:8], obs_pix[96][20:14], obs_pix[96][13:8]);
            end
            checks++;
            if (obs_pix[159][20:8] !== {7'd0, 6'd63} || obs_pix[160][20:8] !== {7'd0, 6'd0}) begin
                errors++;
                $display("FAIL panel_rowwrap got %0d,%0d then %0d,%0d exp 0,63 then 0,0",
                         obs_pix[159][20:14], obs_pix[159][13:8], obs_pix[160][20:14], obs_pix[160][13:8]);
            end
        end
        clear_q();
    endtask

    task automatic test_res();
        i_CS = 0;
        clks(SS + 3);
        send_byte(0, 8'h15); send_byte(0, 8'h20); send_byte(0, 8'h21);
        send_byte(0, 8'h75); send_byte(0, 8'h20); send_byte(0, 8'h21);
        send_byte(0, 8'hAF);
        send_byte(1, 8'h5E);
        checks++;
        if (obs_pix.size() != 1 || obs_pix[0] !== {7'd32, 6'd32, 8'h5E} || o_DISPLAY_ON !== 1'b1) begin
            errors++;
            $display("FAIL res_pre got n=%0d on=%b exp n=1 x=32 y=32 on=1", obs_pix.size(), o_DISPLAY_ON);
        end
        clear_q();
        i_CS = 1;
        clks(2);
        i_RES = 0;
        clks(10);
        i_RES = 1;
        clks(SS + 4);
        model_reset();
        checks++;
        if (o_DISPLAY_ON !== 1'b0) begin
            errors++;
            $display("FAIL res_display got %b exp 0", o_DISPLAY_ON);
        end
        i_CS = 0;
        clks(SS + 3);
        for (int i = 0; i < 97; i++) send_byte(1, 8'($urandom));
        checks++;
        if (obs_pix.size() != 97) begin
            errors++;
            $display("FAIL res_count got %0d exp 97", obs_pix.size());
        end else begin
            checks++;
            if (obs_pix[0][20:8] !== 13'h0 || obs_pix[95][20:8] !== {7'd95, 6'd0} ||
                obs_pix[96][20:8] !== {7'd0, 6'd1}) begin
                errors++;
                $display("FAIL res_window got %0d,%0d %0d,%0d %0d,%0d exp 0,0 95,0 0,1",
                         obs_pix[0][20:14], obs_pix[0][13:8], obs_pix[95][20:14],
                         obs_pix[95][13:8], obs_pix[96][20:14], obs_pix[96][13:8]);
            end
        end
        clear_q();
    endtask

    task automatic test_cs_high();
        int f0;
        f0 = ferr_cnt;
        i_CS = 1;
        clks(SS + 3);
        for (int i = 0; i < 24; i++) begin
            i_MOSI = 1'($urandom);
            i_DC = 1'($urandom);
            i_SCK = ~i_SCK;
            clks(4);
        end
        i_SCK = 0;
        clks(SS + 6);
        checks++;
        if (obs_byte.size() != 0 || obs_cmd.size() != 0 || obs_pix.size() != 0) begin
            errors++;
            $display("FAIL cs_high_strobes got b=%0d c=%0d p=%0d exp 0 0 0",
                     obs_byte.size(), obs_cmd.size(), obs_pix.size());
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL cs_high_ferr got %0d exp %0d", ferr_cnt, f0);
        end
        clear_q();
    endtask

    task automatic test_random();
        int k;
        i_CS = 0;
        clks(SS + 3);
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 7);
            case (k)
                0: begin
                    send_byte(0, 8'h15);
                    send_byte(0, 8'($urandom));
                    send_byte(0, 8'($urandom));
                end
                1: begin
                    send_byte(0, 8'h75);
                    send_byte(0, 8'($urandom));
                    send_byte(0, 8'($urandom));
                end
                2: send_byte(0, $urandom_range(0, 1) ? 8'hAF : 8'hAE);
                3: send_byte(0, 8'($urandom));
                default: begin
                    for (int j = 0; j < $urandom_range(1, 6); j++) send_byte(1, 8'($urandom));
                end
            endcase
        end
        checks++;
        if (obs_byte.size() != exp_byte.size() || obs_cmd.size() != exp_cmd.size() ||
            obs_pix.size() != exp_pix.size()) begin
            errors++;
            $display("FAIL rand_counts got b=%0d c=%0d p=%0d exp b=%0d c=%0d p=%0d",
                     obs_byte.size(), obs_cmd.size(), obs_pix.size(),
                     exp_byte.size(), exp_cmd.size(), exp_pix.size());
        end
        for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
            checks++;
            if (obs_byte[i] !== exp_byte[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got %h exp %h", i, obs_byte[i], exp_byte[i]);
            end
        end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++;
            if (obs_pix[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL rand_pix%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h", i,
                         obs_pix[i][20:14], obs_pix[i][13:8], obs_pix[i][7:0],
                         exp_pix[i][20:14], exp_pix[i][13:8], exp_pix[i][7:0]);
            end
        end
        checks++;
        if (o_DISPLAY_ON !== m_on) begin
            errors++;
            $display("FAIL rand_display got %b exp %b", o_DISPLAY_ON, m_on);
        end
        checks++;
        if (cmd_bad != 0 || pix_bad != 0) begin
            errors++;
            $display("FAIL strobe_timing got cmd_bad=%0d pix_bad=%0d exp 0 0", cmd_bad, pix_bad);
        end
        clear_q();
    endtask

    initial begin
        #3ms;
        errors++;
        $display("FAIL timeout simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mid_reset();
        test_display_on();
        test_window();
        test_frame_err();
        test_latency();
        test_full_panel();
        test_res();
        test_cs_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_spi_monitor.md
OLED_SPI_MONITOR -- requirements
Module: oled_spi_monitor

Interface
REQ-001 Parameter NUM_COL, 96, panel column count; column address range 0..NUM_COL-1.
REQ-002 Parameter NUM_ROW, 64, panel row count; row address range 0..NUM_ROW-1.
REQ-003 Parameter SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).
REQ-004 i_CLK  input  1  system clock, 100 MHz; the only clock in the block.
REQ-005 i_RST  input  1  reset, synchronous and active-high.
REQ-006 i_CS  input  1  SPI chip select, active-low, asynchronous to i_CLK.
REQ-007 i_SCK  input  1  SPI serial clock, asynchronous; SCK period is at least 8 i_CLK periods.
REQ-008 i_MOSI  input  1  SPI serial data, MSB first.
REQ-009 i_DC  input  1  0 = command byte, 1 = data byte.
REQ-010 i_RES  input  1  panel reset, active-low.
REQ-011 o_BYTE  output  8  last received byte.
REQ-012 o_BYTE_DC  output  1  i_DC value latched with o_BYTE.
REQ-013 o_BYTE_VALID  output  1  one-cycle strobe; a new byte is on o_BYTE.
REQ-014 o_CMD_VALID  output  1  one-cycle strobe; o_BYTE is a command or command argument.
REQ-015 o_PIX_VALID  output  1  one-cycle strobe; a pixel write occurred.
REQ-016 o_PIX_X  output  7  column of the pixel write.
REQ-017 o_PIX_Y  output  6  row of the pixel write.
REQ-018 o_PIX_DATA  output  8  8-bit RRRGGGBB colour of the pixel write.
REQ-019 o_DISPLAY_ON  output  1  1 after command 0xAF, 0 after command 0xAE.
REQ-020 o_FRAME_ERR  output  1  one-cycle strobe; CS deasserted while a byte is partially received.

Function
REQ-021 The block SHALL pass i_CS, i_SCK, i_MOSI, i_DC and i_RES through SYNC_STAGES-deep synchronizers before use; the i_CS and i_SCK synchronizers reset to 1.
REQ-022 The block SHALL sample MOSI on each synchronized SCK rising edge (0->1) while synchronized CS = 0, shifting the sample into the LSB of an 8-bit shift register.
REQ-023 The block SHALL keep a 3-bit bit counter; on the 8th sample it SHALL load o_BYTE, load o_BYTE_DC from synchronized DC, pulse o_BYTE_VALID, and clear the counter.
REQ-024 Latency: o_BYTE_VALID SHALL assert exactly SYNC_STAGES+2 i_CLK cycles after the physical 8th SCK rising edge.
REQ-025 If CS rises while the bit counter is nonzero, the block SHALL clear the counter, discard the partial byte and pulse o_FRAME_ERR; if CS rises with the counter at 0, no strobe.
REQ-026 SCK edges while CS = 1 SHALL be ignored; CS falling SHALL clear the bit counter.
REQ-027 Parser states: IDLE, COL_S, COL_E, ROW_S, ROW_E; transitions occur only on o_BYTE_VALID.
REQ-028 IDLE, command 0x15 -> COL_S -> COL_E -> IDLE; each argument byte (DC = 0) is stored as col_start/col_end (low 7 bits).
REQ-029 IDLE, command 0x75 -> ROW_S -> ROW_E -> IDLE; arguments are stored as row_start/row_end (low 6 bits).
REQ-030 Completing COL_E SHALL set x = col_start; completing ROW_E SHALL set y = row_start.
REQ-031 Command 0xAF SHALL set o_DISPLAY_ON; 0xAE SHALL clear it; other commands leave the parser in IDLE.
REQ-032 Every DC = 0 byte, including arguments, SHALL pulse o_CMD_VALID one cycle after o_BYTE_VALID.
REQ-033 A DC = 1 byte received in any state SHALL produce o_PIX_VALID one cycle after o_BYTE_VALID, with o_PIX_X = x, o_PIX_Y = y and o_PIX_DATA = byte; the parser state is unchanged.
REQ-034 After each pixel, x SHALL increment; if x = col_end, x wraps to col_start and y increments.
REQ-035 If y = row_end on that wrap, y SHALL wrap to row_start.
REQ-036 Wrap comparisons SHALL use equality only; if start > end, x/y count to 127/63, roll over modulo width and continue until equality.
REQ-037 Synchronized RES = 0 SHALL hold the receiver and parser in reset: window = 0..NUM_COL-1 / 0..NUM_ROW-1, x = y = 0, o_DISPLAY_ON = 0, state IDLE, no strobes.

Reset
REQ-038 On i_RST = 1 at an i_CLK edge, all strobes, o_BYTE, o_BYTE_DC, o_PIX_X, o_PIX_Y, o_PIX_DATA and o_DISPLAY_ON SHALL be 0; the bit counter is 0; the state is IDLE; and the window is the full panel.
REQ-039 An i_RST assertion mid-byte SHALL discard the partial byte without pulsing o_FRAME_ERR.

Verification
REQ-040 CS low, DC = 0, byte 0xAF -> o_BYTE_VALID with o_BYTE = 0xAF and o_BYTE_DC = 0; o_CMD_VALID one cycle later; o_DISPLAY_ON = 1.
REQ-041 Send 0x15,0x10,0x12 then 0x75,0x05,0x06, then data 0x01..0x07 -> pixels (16,5),(17,5),(18,5),(16,6),(17,6),(18,6),(16,5) with data 0x01..0x07.
REQ-042 Send 5 bits, then raise CS -> o_FRAME_ERR pulses once, no o_BYTE_VALID; the next full byte 0xA5 is received correctly.
REQ-043 After reset, send 96*64 data bytes -> the last pixel is at (95,63) and the next pixel is at (0,0).
REQ-044 Set the window to 0x20..0x21, then pull i_RES low for 10 cycles -> the window returns to 0..95 / 0..63, x = y = 0 and o_DISPLAY_ON = 0.
REQ-045 Toggle SCK with CS high -> no strobes at all.
